// File: rtl/riscv_v_lmul_sequencer_if.sv
// -----------------------------------------------------------------------------
// riscv_v_lmul_sequencer_if
//   Bundles every non-clock signal of the LMUL sequencer: the instruction
//   handshake from vector issue, the uop handshake towards decode-element,
//   and the flush/busy/done side-band.
//   Modports:
//     master : the environment (issue side drives instr_*, consumer drives
//              uop_ready, pipeline control drives flush)
//     slave  : the sequencer itself
//   Parameter VLEN_BYTES sets the vl/vstart widths:
//     VL_W  = $clog2(VLEN_BYTES*8)+1   (instruction vl/vstart)
//     EVL_W = $clog2(VLEN_BYTES)+1     (per-uop vl/vstart)
// -----------------------------------------------------------------------------
interface riscv_v_lmul_sequencer_if #(
  parameter int VLEN_BYTES = 16
);
  localparam int VL_W  = $clog2(VLEN_BYTES*8) + 1;
  localparam int EVL_W = $clog2(VLEN_BYTES) + 1;

  // instruction side
  logic             instr_valid;
  logic             instr_ready;
  logic [4:0]       instr_vd;
  logic [4:0]       instr_vs1;
  logic [4:0]       instr_vs2;
  logic [2:0]       vtype_vsew;
  logic [2:0]       vtype_vlmul;
  logic [VL_W-1:0]  vl;
  logic [VL_W-1:0]  vstart;
  logic             flush;

  // uop side
  logic             uop_valid;
  logic             uop_ready;
  logic [4:0]       uop_vd;
  logic [4:0]       uop_vs1;
  logic [4:0]       uop_vs2;
  logic [EVL_W-1:0] uop_vl;
  logic [EVL_W-1:0] uop_vstart;
  logic             uop_first;
  logic             uop_last;

  // status
  logic             busy;
  logic             instr_done;
  logic             vstart_clr;

  modport master (
    output instr_valid, instr_vd, instr_vs1, instr_vs2, vtype_vsew, vtype_vlmul,
           vl, vstart, flush, uop_ready,
    input  instr_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_vl, uop_vstart,
           uop_first, uop_last, busy, instr_done, vstart_clr
  );

  modport slave (
    input  instr_valid, instr_vd, instr_vs1, instr_vs2, vtype_vsew, vtype_vlmul,
           vl, vstart, flush, uop_ready,
    output instr_ready, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_vl, uop_vstart,
           uop_first, uop_last, busy, instr_done, vstart_clr
  );
endinterface

// File: rtl/riscv_v_lmul_sequencer.sv
// -----------------------------------------------------------------------------
// riscv_v_lmul_sequencer
//   Splits one accepted vector instruction into one micro-op per register of
//   its LMUL group, giving each uop a register-local vl/vstart so the element
//   stage only ever sees a single-register slice. One instruction in flight.
//
//   Ports:
//     clk    : clock
//     rst_n  : asynchronous active-low reset
//     bus    : riscv_v_lmul_sequencer_if.slave
//              instr_valid/instr_ready + instr_vd/vs1/vs2, vtype_vsew,
//              vtype_vlmul, vl, vstart  (accepted in IDLE only)
//              uop_valid/uop_ready + uop_vd/vs1/vs2, uop_vl, uop_vstart,
//              uop_first, uop_last
//              flush (sync abort), busy, instr_done, vstart_clr
//
//   Parameters: VLEN_BYTES (bytes per register), MAX_LMUL (max group size).
//
//   Optional feature, macro RISCV_V_SEQ_SKIP_EN:
//     defined   - uops whose uop_vstart >= uop_vl are never presented; the
//                 next qualifying register is found combinationally, so a
//                 skip costs no cycle. First/last mark the issued uops.
//     undefined - every register of the group is issued; inactive elements
//                 are masked downstream.
// -----------------------------------------------------------------------------
module riscv_v_lmul_sequencer #(
  parameter int VLEN_BYTES = 16,
  parameter int MAX_LMUL   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  riscv_v_lmul_sequencer_if.slave        bus
);
  localparam int VL_W  = $clog2(VLEN_BYTES*8) + 1;
  localparam int EVL_W = $clog2(VLEN_BYTES) + 1;
  localparam int K_W   = $clog2(MAX_LMUL);
  localparam int N_W   = K_W + 1;            // holds 0..MAX_LMUL
  localparam int B_W   = VL_W + 1;           // element base k*EPR plus headroom

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Active elements of register kk within [0, total): clamp(total - kk*epr, 0, epr).
  function automatic logic [EVL_W-1:0] slice(input logic [VL_W-1:0]  total,
                                             input int               kk,
                                             input logic [EVL_W-1:0] epr);
    logic [B_W-1:0] base;
    logic [B_W-1:0] rem;
    base = B_W'(kk) * B_W'(epr);
    rem  = ({1'b0, total} > base) ? ({1'b0, total} - base) : '0;
    return (rem > B_W'(epr)) ? epr : rem[EVL_W-1:0];
  endfunction

  // Registered state and captured instruction
  state_t           r_state;
  logic [4:0]       r_vd;
  logic [4:0]       r_vs1;
  logic [4:0]       r_vs2;
  logic [2:0]       r_vsew;
  logic [VL_W-1:0]  r_vl;
  logic [VL_W-1:0]  r_vstart;
  logic [N_W-1:0]   r_num_uops;
  logic [K_W-1:0]   r_k;

  // Registered outputs
  logic             r_instr_ready;
  logic             r_busy;
  logic             r_uop_valid;
  logic [4:0]       r_uop_vd;
  logic [4:0]       r_uop_vs1;
  logic [4:0]       r_uop_vs2;
  logic [EVL_W-1:0] r_uop_vl;
  logic [EVL_W-1:0] r_uop_vstart;
  logic             r_uop_first;
  logic             r_uop_last;
  logic             r_instr_done;
  logic             r_vstart_clr;

  // Next-uop selection
  logic             w_idle;
  logic [N_W-1:0]   w_in_num;
  logic [N_W-1:0]   w_src_num;
  logic [2:0]       w_src_vsew;
  logic [VL_W-1:0]  w_src_vl;
  logic [VL_W-1:0]  w_src_vstart;
  logic [4:0]       w_src_vd;
  logic [4:0]       w_src_vs1;
  logic [4:0]       w_src_vs2;
  logic [EVL_W-1:0] w_epr;
  logic [N_W-1:0]   w_start;
  logic             w_qual  [MAX_LMUL];
  logic [EVL_W-1:0] w_k_vl  [MAX_LMUL];
  logic [EVL_W-1:0] w_k_vs  [MAX_LMUL];
  logic             w_found;
  logic [K_W-1:0]   w_sel_k;
  logic             w_sel_last;
  logic [EVL_W-1:0] w_sel_vl;
  logic [EVL_W-1:0] w_sel_vs;
  logic [4:0]       w_sel_vd;
  logic [4:0]       w_sel_vs1;
  logic [4:0]       w_sel_vs2;
  logic             w_uop_hs;

  // The same selection logic serves both the first uop (straight from the
  // instruction inputs while IDLE) and every following uop (from the captured
  // copy), which is what makes back-to-back uops bubble-free.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch or
    // loop so no path leaves it unassigned and no latch is inferred.
    w_idle       = (r_state == ST_IDLE);
    w_in_num     = (bus.vtype_vlmul < 3'd4) ? (N_W'(1) << bus.vtype_vlmul[1:0]) : N_W'(1);
    if (w_in_num > N_W'(MAX_LMUL)) w_in_num = N_W'(MAX_LMUL);
    w_src_num    = w_idle ? w_in_num         : r_num_uops;
    w_src_vsew   = w_idle ? bus.vtype_vsew   : r_vsew;
    w_src_vl     = w_idle ? bus.vl           : r_vl;
    w_src_vstart = w_idle ? bus.vstart       : r_vstart;
    w_src_vd     = w_idle ? bus.instr_vd     : r_vd;
    w_src_vs1    = w_idle ? bus.instr_vs1    : r_vs1;
    w_src_vs2    = w_idle ? bus.instr_vs2    : r_vs2;
    w_epr        = EVL_W'(VLEN_BYTES >> w_src_vsew);
    w_start      = w_idle ? '0 : ({1'b0, r_k} + N_W'(1));

    for (int kk = 0; kk < MAX_LMUL; kk++) begin
      w_k_vl[kk] = slice(w_src_vl, kk, w_epr);
      w_k_vs[kk] = slice(w_src_vstart, kk, w_epr);
`ifdef RISCV_V_SEQ_SKIP_EN
      w_qual[kk] = (N_W'(kk) < w_src_num) && (w_k_vs[kk] < w_k_vl[kk]);
`else
      w_qual[kk] = (N_W'(kk) < w_src_num);
`endif
    end

    // Lowest qualifying register at or after the start point.
    w_found = 1'b0;
    w_sel_k = '0;
    for (int kk = MAX_LMUL - 1; kk >= 0; kk--) begin
      if (w_qual[kk] && (N_W'(kk) >= w_start)) begin
        w_found = 1'b1;
        w_sel_k = K_W'(kk);
      end
    end

    // Last if nothing qualifies beyond the selected register.
    w_sel_last = 1'b1;
    for (int kk = 0; kk < MAX_LMUL; kk++) begin
      if (w_qual[kk] && (N_W'(kk) > {1'b0, w_sel_k})) w_sel_last = 1'b0;
    end

    w_sel_vl  = w_k_vl[w_sel_k];
    w_sel_vs  = w_k_vs[w_sel_k];
    // Register indices wrap modulo 32 by the 5-bit add.
    w_sel_vd  = w_src_vd  + 5'(w_sel_k);
    w_sel_vs1 = w_src_vs1 + 5'(w_sel_k);
    w_sel_vs2 = w_src_vs2 + 5'(w_sel_k);
    w_uop_hs  = r_uop_valid & bus.uop_ready;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_vd          <= '0;
      r_vs1         <= '0;
      r_vs2         <= '0;
      r_vsew        <= '0;
      r_vl          <= '0;
      r_vstart      <= '0;
      r_num_uops    <= '0;
      r_k           <= '0;
      r_instr_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_uop_valid   <= 1'b0;
      r_uop_vd      <= '0;
      r_uop_vs1     <= '0;
      r_uop_vs2     <= '0;
      r_uop_vl      <= '0;
      r_uop_vstart  <= '0;
      r_uop_first   <= 1'b0;
      r_uop_last    <= 1'b0;
      r_instr_done  <= 1'b0;
      r_vstart_clr  <= 1'b0;
    end else begin
      r_instr_done <= 1'b0;
      r_vstart_clr <= 1'b0;

      if (bus.flush) begin
        // Abort wins over everything, including an offered instruction.
        r_state       <= ST_IDLE;
        r_instr_ready <= 1'b1;
        r_busy        <= 1'b0;
        r_uop_valid   <= 1'b0;
        r_uop_first   <= 1'b0;
        r_uop_last    <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (bus.instr_valid) begin
              r_state       <= ST_ISSUE;
              r_instr_ready <= 1'b0;
              r_busy        <= 1'b1;
              r_vd          <= bus.instr_vd;
              r_vs1         <= bus.instr_vs1;
              r_vs2         <= bus.instr_vs2;
              r_vsew        <= bus.vtype_vsew;
              r_vl          <= bus.vl;
              r_vstart      <= bus.vstart;
              r_num_uops    <= w_in_num;
              r_k           <= w_sel_k;
              // With skipping enabled nothing may qualify; ISSUE then falls
              // straight through to DONE without ever raising uop_valid.
              r_uop_valid   <= w_found;
              r_uop_first   <= w_found;
              r_uop_last    <= w_sel_last;
              r_uop_vd      <= w_sel_vd;
              r_uop_vs1     <= w_sel_vs1;
              r_uop_vs2     <= w_sel_vs2;
              r_uop_vl      <= w_sel_vl;
              r_uop_vstart  <= w_sel_vs;
            end
          end

          ST_ISSUE: begin
            if (!r_uop_valid || (w_uop_hs && r_uop_last)) begin
              r_state      <= ST_DONE;
              r_uop_valid  <= 1'b0;
              r_uop_first  <= 1'b0;
              r_uop_last   <= 1'b0;
              r_instr_done <= 1'b1;
              r_vstart_clr <= 1'b1;
            end else if (w_uop_hs) begin
              // A non-last uop guarantees a further qualifying register.
              r_k          <= w_sel_k;
              r_uop_first  <= 1'b0;
              r_uop_last   <= w_sel_last;
              r_uop_vd     <= w_sel_vd;
              r_uop_vs1    <= w_sel_vs1;
              r_uop_vs2    <= w_sel_vs2;
              r_uop_vl     <= w_sel_vl;
              r_uop_vstart <= w_sel_vs;
            end
          end

          ST_DONE: begin
            r_state       <= ST_IDLE;
            r_instr_ready <= 1'b1;
            r_busy        <= 1'b0;
          end

          default: begin
            r_state       <= ST_IDLE;
            r_instr_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_uop_valid   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.instr_ready = r_instr_ready;
  assign bus.busy        = r_busy;
  assign bus.uop_valid   = r_uop_valid;
  assign bus.uop_vd      = r_uop_vd;
  assign bus.uop_vs1     = r_uop_vs1;
  assign bus.uop_vs2     = r_uop_vs2;
  assign bus.uop_vl      = r_uop_vl;
  assign bus.uop_vstart  = r_uop_vstart;
  assign bus.uop_first   = r_uop_first;
  assign bus.uop_last    = r_uop_last;
  assign bus.instr_done  = r_instr_done;
  assign bus.vstart_clr  = r_vstart_clr;
endmodule

// File: tb/tb_riscv_v_lmul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_riscv_v_lmul_sequencer
//   Self-checking bench for riscv_v_lmul_sequencer (VLEN_BYTES=16, MAX_LMUL=8).
//   A reference model expands each instruction into its expected uop list with
//   plain arithmetic; observed uops are compared on every handshake.
//   Honours RISCV_V_SEQ_SKIP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_riscv_v_lmul_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_v_lmul_sequencer_if #(.VLEN_BYTES(16)) sif ();

  riscv_v_lmul_sequencer #(.VLEN_BYTES(16), .MAX_LMUL(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  typedef struct {
    logic [4:0] vd, vs1, vs2;
    int         vl, vs;
    bit         first, last;
  } uop_t;

  int checks = 0;
  int errors = 0;
  int obs_vl[$];
  int obs_vs[$];
  int obs_vd[$];

  function automatic logic [27:0] snap();
    return {sif.uop_valid, sif.uop_vd, sif.uop_vs1, sif.uop_vs2,
            sif.uop_vl, sif.uop_vstart, sif.uop_first, sif.uop_last};
  endfunction

  // Runs one instruction to completion. hold0 forces uop_ready low for the
  // first hold0 cycles; afterwards uop_ready is low with probability stall_pct.
  task automatic run_instr(input int vd, input int vs1, input int vs2,
                           input int vsew, input int vlmul, input int vl,
                           input int vstart, input int stall_pct, input int hold0);
    uop_t        exp_q[$];
    uop_t        e;
    int          num, epr, cyc, n_exp;
    bit          holding;
    logic [27:0] hold_val, exp_val;

    // reference model
    num = (vlmul < 4) ? (1 << vlmul) : 1;
    epr = 16 >> vsew;
    for (int k = 0; k < num; k++) begin
      int base, l, s;
      base = k * epr;
      l = (vl > base) ? (((vl - base) < epr) ? (vl - base) : epr) : 0;
      s = (vstart > base) ? (((vstart - base) < epr) ? (vstart - base) : epr) : 0;
`ifdef RISCV_V_SEQ_SKIP_EN
      if (s >= l) continue;
`endif
      e.vd = 5'(vd + k); e.vs1 = 5'(vs1 + k); e.vs2 = 5'(vs2 + k);
      e.vl = l; e.vs = s; e.first = 1'b0; e.last = 1'b0;
      exp_q.push_back(e);
    end
    n_exp = exp_q.size();
    if (n_exp > 0) begin
      exp_q[0].first = 1'b1;
      exp_q[n_exp-1].last = 1'b1;
    end
    obs_vl.delete(); obs_vs.delete(); obs_vd.delete();

    checks++;
    if (sif.instr_ready !== 1'b1) begin
      errors++; $display("FAIL accept_ready got=%b exp=1", sif.instr_ready);
    end
    sif.instr_vd = 5'(vd); sif.instr_vs1 = 5'(vs1); sif.instr_vs2 = 5'(vs2);
    sif.vtype_vsew = 3'(vsew); sif.vtype_vlmul = 3'(vlmul);
    sif.vl = 8'(vl); sif.vstart = 8'(vstart);
    sif.instr_valid = 1'b1;
    @(negedge clk);
    sif.instr_valid = 1'b0;
    checks++;
    if (sif.busy !== 1'b1 || sif.instr_ready !== 1'b0) begin
      errors++; $display("FAIL accept_state busy=%b ready=%b exp busy=1 ready=0", sif.busy, sif.instr_ready);
    end

    cyc = 0; holding = 1'b0; hold_val = '0;
    while (exp_q.size() != 0 && cyc < 300) begin
      if (holding) begin
        checks++;
        if (snap() !== hold_val) begin
          errors++; $display("FAIL stall_stable got=%h exp=%h", snap(), hold_val);
        end
      end
      sif.uop_ready = (cyc >= hold0) && ($urandom_range(99) >= stall_pct);
      holding = 1'b0;
      if (sif.uop_valid === 1'b1) begin
        if (sif.uop_ready) begin
          e = exp_q.pop_front();
          exp_val = {1'b1, e.vd, e.vs1, e.vs2, 5'(e.vl), 5'(e.vs), e.first, e.last};
          obs_vl.push_back(int'(sif.uop_vl));
          obs_vs.push_back(int'(sif.uop_vstart));
          obs_vd.push_back(int'(sif.uop_vd));
          checks++;
          if (snap() !== exp_val) begin
            errors++; $display("FAIL uop_fields got=%h exp=%h", snap(), exp_val);
          end
        end else begin
          holding = 1'b1;
          hold_val = snap();
        end
      end
      @(negedge clk);
      cyc++;
    end
    sif.uop_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL uop_timeout got=%0d exp=0 pending", exp_q.size());
    end

    if (n_exp > 0) begin
      // one cycle after the last handshake: the done pulse
      checks++;
      if (sif.instr_done !== 1'b1 || sif.vstart_clr !== 1'b1 ||
          sif.instr_ready !== 1'b0 || sif.uop_valid !== 1'b0) begin
        errors++; $display("FAIL done_pulse done=%b clr=%b ready=%b valid=%b exp 1 1 0 0",
                           sif.instr_done, sif.vstart_clr, sif.instr_ready, sif.uop_valid);
      end
    end else begin
      cyc = 0;
      while (sif.instr_done !== 1'b1 && cyc < 10) begin
        checks++;
        if (sif.uop_valid !== 1'b0) begin
          errors++; $display("FAIL no_uop_expected got valid=%b exp=0", sif.uop_valid);
        end
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (sif.instr_done !== 1'b1 || sif.vstart_clr !== 1'b1) begin
        errors++; $display("FAIL empty_done done=%b clr=%b exp 1 1", sif.instr_done, sif.vstart_clr);
      end
    end
    @(negedge clk);
    checks++;
    if (sif.instr_done !== 1'b0 || sif.instr_ready !== 1'b1 || sif.busy !== 1'b0) begin
      errors++; $display("FAIL back_to_idle done=%b ready=%b busy=%b exp 0 1 0",
                         sif.instr_done, sif.instr_ready, sif.busy);
    end
  endtask

  task automatic check_seq(input string name, input int got[$], input int exp[$]);
    bit ok;
    ok = (got.size() == exp.size());
    if (ok) for (int i = 0; i < exp.size(); i++) if (got[i] != exp[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s got=%p exp=%p", name, got, exp);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (sif.instr_ready !== 1'b1 || sif.uop_valid !== 1'b0 || sif.busy !== 1'b0 ||
        sif.instr_done !== 1'b0 || sif.vstart_clr !== 1'b0 || sif.uop_first !== 1'b0 ||
        sif.uop_last !== 1'b0 || snap() !== 28'h0) begin
      errors++; $display("FAIL reset_state ready=%b uop=%h busy=%b done=%b clr=%b exp ready=1 rest 0",
                         sif.instr_ready, snap(), sif.busy, sif.instr_done, sif.vstart_clr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sew32_lmul4();
    run_instr(8, 16, 24, 2, 2, 10, 0, 0, 0);
`ifdef RISCV_V_SEQ_SKIP_EN
    check_seq("sew32_vl_seq", obs_vl, '{4, 4, 2});
    check_seq("sew32_vd_seq", obs_vd, '{8, 9, 10});
`else
    check_seq("sew32_vl_seq", obs_vl, '{4, 4, 2, 0});
    check_seq("sew32_vd_seq", obs_vd, '{8, 9, 10, 11});
`endif
    run_instr(8, 16, 24, 2, 2, 10, 5, 0, 0);
`ifdef RISCV_V_SEQ_SKIP_EN
    check_seq("vstart5_vs_seq", obs_vs, '{1, 0});
    check_seq("vstart5_vd_seq", obs_vd, '{9, 10});
`else
    check_seq("vstart5_vs_seq", obs_vs, '{4, 1, 0, 0});
`endif
  endtask

  task automatic test_stall();
    run_instr(3, 4, 5, 0, 0, 16, 0, 0, 3);
    check_seq("stall_vl", obs_vl, '{16});
  endtask

  task automatic test_wrap();
    run_instr(28, 30, 1, 0, 3, 128, 0, 20, 0);
    check_seq("wrap_vd_seq", obs_vd, '{28, 29, 30, 31, 0, 1, 2, 3});
  endtask

  task automatic test_vl_zero();
    run_instr(0, 0, 0, 1, 1, 0, 0, 0, 0);
`ifdef RISCV_V_SEQ_SKIP_EN
    check_seq("vl0_count", obs_vl, '{});
`else
    check_seq("vl0_count", obs_vl, '{0, 0});
`endif
  endtask

  task automatic test_flush();
    int cyc;
    sif.instr_vd = 5'd0; sif.instr_vs1 = 5'd0; sif.instr_vs2 = 5'd0;
    sif.vtype_vsew = 3'd0; sif.vtype_vlmul = 3'd3;
    sif.vl = 8'd128; sif.vstart = 8'd0;
    sif.instr_valid = 1'b1;
    @(negedge clk);
    sif.instr_valid = 1'b0;
    sif.uop_ready = 1'b1;
    cyc = 0;
    while (!(sif.uop_valid === 1'b1 && sif.uop_vd === 5'd2) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 20) begin
      errors++; $display("FAIL flush_reach_k2 got vd=%0d exp=2", sif.uop_vd);
    end
    sif.flush = 1'b1;
    @(negedge clk);
    sif.flush = 1'b0;
    sif.uop_ready = 1'b0;
    checks++;
    if (sif.uop_valid !== 1'b0 || sif.instr_ready !== 1'b1 || sif.busy !== 1'b0 ||
        sif.instr_done !== 1'b0 || sif.vstart_clr !== 1'b0) begin
      errors++; $display("FAIL flush_idle valid=%b ready=%b busy=%b done=%b clr=%b exp 0 1 0 0 0",
                         sif.uop_valid, sif.instr_ready, sif.busy, sif.instr_done, sif.vstart_clr);
    end
    @(negedge clk);
    checks++;
    if (sif.instr_done !== 1'b0 || sif.uop_valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_done done=%b valid=%b exp 0 0", sif.instr_done, sif.uop_valid);
    end
    // flush together with an offered instruction: not accepted
    sif.instr_valid = 1'b1;
    sif.flush = 1'b1;
    @(negedge clk);
    sif.instr_valid = 1'b0;
    sif.flush = 1'b0;
    checks++;
    if (sif.busy !== 1'b0 || sif.instr_ready !== 1'b1 || sif.uop_valid !== 1'b0) begin
      errors++; $display("FAIL flush_blocks_accept busy=%b ready=%b valid=%b exp 0 1 0",
                         sif.busy, sif.instr_ready, sif.uop_valid);
    end
    run_instr(6, 7, 8, 2, 1, 8, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    sif.instr_vd = 5'd1; sif.instr_vs1 = 5'd2; sif.instr_vs2 = 5'd3;
    sif.vtype_vsew = 3'd0; sif.vtype_vlmul = 3'd1;
    sif.vl = 8'd20; sif.vstart = 8'd0;
    sif.instr_valid = 1'b1;
    sif.uop_ready = 1'b0;
    @(negedge clk);
    sif.instr_valid = 1'b0;
    checks++;
    if (sif.uop_valid !== 1'b1) begin
      errors++; $display("FAIL arst_pre_valid got=%b exp=1", sif.uop_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sif.uop_valid !== 1'b0 || sif.instr_ready !== 1'b1 || sif.busy !== 1'b0 || snap() !== 28'h0) begin
      errors++; $display("FAIL arst_immediate valid=%b ready=%b busy=%b uop=%h exp 0 1 0 0",
                         sif.uop_valid, sif.instr_ready, sif.busy, snap());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_instr(10, 11, 12, 1, 2, 30, 3, 25, 0);
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 40; i++) begin
      run_instr($urandom_range(31), $urandom_range(31), $urandom_range(31),
                $urandom_range(4), $urandom_range(7), $urandom_range(128),
                $urandom_range(127), 30, 0);
    end
  endtask

  initial begin
    sif.instr_valid = 1'b0; sif.instr_vd = '0; sif.instr_vs1 = '0; sif.instr_vs2 = '0;
    sif.vtype_vsew = '0; sif.vtype_vlmul = '0; sif.vl = '0; sif.vstart = '0;
    sif.flush = 1'b0; sif.uop_ready = 1'b0;
    test_reset();
    test_sew32_lmul4();
    test_stall();
    test_wrap();
    test_vl_zero();
    test_flush();
    test_async_reset();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
